// File: rtl/kara_seq_ctrl_if.sv
// Operand, result and core buses of the Karatsuba sequencer.
// slave is the sequencer side; master is the source/sink/core side.
interface kara_seq_ctrl_if #(
  parameter int N = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2*N-1:0]   in_a;
  logic [2*N-1:0]   in_b;
  logic             out_valid;
  logic             out_ready;
  logic [4*N-1:0]   out_r;
  logic [N:0]       core_u;
  logic [N:0]       core_v;
  logic [2*N+1:0]   core_r;

  modport master (
    output in_valid, in_a, in_b, out_ready, core_r,
    input  in_ready, out_valid, out_r, core_u, core_v
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready, core_r,
    output in_ready, out_valid, out_r, core_u, core_v
  );
endinterface

// File: rtl/kara_seq_ctrl.sv
// 2N x 2N multiplier sequencer: three passes through an external (N+1)-bit core, then combine.
// Define KARA_SEQ_CHECK_EN to add a sticky err output fed by a behavioural reference product.
module kara_seq_ctrl #(
  parameter int N        = 8,
  parameter int CORE_LAT = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  kara_seq_ctrl_if.slave bus
`ifdef KARA_SEQ_CHECK_EN
  ,
  output logic           err
`endif
);

  localparam int CW = (CORE_LAT > 0) ? $clog2(CORE_LAT + 1) : 1;
  localparam logic [CW-1:0] LAST_WAIT = CW'(CORE_LAT);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_P0   = 3'd1,
    S_P2   = 3'd2,
    S_PM   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_wait;
  logic [N-1:0]     r_a0;
  logic [N-1:0]     r_a1;
  logic [N-1:0]     r_b0;
  logic [N-1:0]     r_b1;
  logic [2*N-1:0]   r_p0;
  logic [2*N-1:0]   r_p2;
  logic [4*N-1:0]   r_out_r;
  logic             r_out_valid;
  logic [N:0]       r_core_u;
  logic [N:0]       r_core_v;

  logic             w_last;
  logic             w_accept;
  logic             w_take;
  logic [N:0]       w_sum_a;
  logic [N:0]       w_sum_b;
  logic [2*N+1:0]   w_mid;
  logic [4*N-1:0]   w_prod;

  assign w_last   = (r_wait == LAST_WAIT);
  assign w_accept = bus.in_valid && (r_state == S_IDLE);
  assign w_take   = r_out_valid && bus.out_ready;
  assign w_sum_a  = {1'b0, r_a0} + {1'b0, r_a1};
  assign w_sum_b  = {1'b0, r_b0} + {1'b0, r_b1};

  // Middle term from the live PM product; its top bit is always zero but kept so the sum is exact.
  assign w_mid  = bus.core_r - {2'b00, r_p0} - {2'b00, r_p2};
  assign w_prod = {r_p2, {(2*N){1'b0}}}
                + {{(N-2){1'b0}}, w_mid, {N{1'b0}}}
                + {{(2*N){1'b0}}, r_p0};

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.out_r     = r_out_r;
  assign bus.core_u    = r_core_u;
  assign bus.core_v    = r_core_v;

  // Pass sequencer: operand latch, per-pass wait count, partial-product capture and result hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_wait      <= '0;
      r_a0        <= '0;
      r_a1        <= '0;
      r_b0        <= '0;
      r_b1        <= '0;
      r_p0        <= '0;
      r_p2        <= '0;
      r_out_r     <= '0;
      r_out_valid <= 1'b0;
      r_core_u    <= '0;
      r_core_v    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a0     <= bus.in_a[N-1:0];
            r_a1     <= bus.in_a[2*N-1:N];
            r_b0     <= bus.in_b[N-1:0];
            r_b1     <= bus.in_b[2*N-1:N];
            r_core_u <= {1'b0, bus.in_a[N-1:0]};
            r_core_v <= {1'b0, bus.in_b[N-1:0]};
            r_wait   <= '0;
            r_state  <= S_P0;
          end else begin
            r_state  <= S_IDLE;
          end
        end
        S_P0: begin
          if (w_last) begin
            r_p0     <= bus.core_r[2*N-1:0];
            r_core_u <= {1'b0, r_a1};
            r_core_v <= {1'b0, r_b1};
            r_wait   <= '0;
            r_state  <= S_P2;
          end else begin
            r_wait   <= r_wait + CW'(1);
          end
        end
        S_P2: begin
          if (w_last) begin
            r_p2     <= bus.core_r[2*N-1:0];
            r_core_u <= w_sum_a;
            r_core_v <= w_sum_b;
            r_wait   <= '0;
            r_state  <= S_PM;
          end else begin
            r_wait   <= r_wait + CW'(1);
          end
        end
        S_PM: begin
          if (w_last) begin
            r_out_r     <= w_prod;
            r_out_valid <= 1'b1;
            r_core_u    <= '0;
            r_core_v    <= '0;
            r_wait      <= '0;
            r_state     <= S_DONE;
          end else begin
            r_wait      <= r_wait + CW'(1);
          end
        end
        S_DONE: begin
          if (w_take) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_state     <= S_DONE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_wait      <= '0;
          r_out_valid <= 1'b0;
          r_core_u    <= '0;
          r_core_v    <= '0;
        end
      endcase
    end
  end

`ifdef KARA_SEQ_CHECK_EN
  logic [4*N-1:0] w_ref;

  assign w_ref = (4*N)'({r_a1, r_a0}) * (4*N)'({r_b1, r_b0});

  // Sticky flag: assembled result disagrees with the reference product at PM capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if ((r_state == S_PM) && w_last && (w_prod != w_ref)) begin
      err <= 1'b1;
    end else begin
      err <= err;
    end
  end
`endif

endmodule

// File: tb/tb_kara_seq_ctrl.sv
// Scoreboard bench: two sequencers (CORE_LAT 0 and 2) each with a behavioural core model.
module tb_kara_seq_ctrl;
  localparam int N = 8;

  typedef struct {
    logic [31:0] res;
    int          acc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   checks   = 0;
  int   failures = 0;
  bit   mon_en   = 1'b0;
  bit   rnd_done = 1'b0;
  int   lat [2];
  bit   prev_valid [2];
  bit   after_take [2];
  exp_t q0 [$];
  exp_t q1 [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  kara_seq_ctrl_if #(.N(N)) if0 ();
  kara_seq_ctrl_if #(.N(N)) if1 ();

`ifdef KARA_SEQ_CHECK_EN
  logic err0;
  logic err1;
`endif

  kara_seq_ctrl #(.N(N), .CORE_LAT(0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0)
`ifdef KARA_SEQ_CHECK_EN
    , .err (err0)
`endif
  );

  kara_seq_ctrl #(.N(N), .CORE_LAT(2)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
`ifdef KARA_SEQ_CHECK_EN
    , .err (err1)
`endif
  );

  // Core models: combinational for dut0, two register stages for dut1.
  logic [17:0] pipe1;
  logic [17:0] pipe2;
  assign if0.core_r = {9'd0, if0.core_u} * {9'd0, if0.core_v};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe1 <= 18'd0;
      pipe2 <= 18'd0;
    end else begin
      pipe1 <= {9'd0, if1.core_u} * {9'd0, if1.core_v};
      pipe2 <= pipe1;
    end
  end
  assign if1.core_r = pipe2;

  logic        w_ov   [2];
  logic        w_ir   [2];
  logic        w_ordy [2];
  logic [31:0] w_or   [2];
  logic [8:0]  w_cu   [2];
  logic [8:0]  w_cv   [2];
  assign w_ov[0] = if0.out_valid;  assign w_ov[1] = if1.out_valid;
  assign w_ir[0] = if0.in_ready;   assign w_ir[1] = if1.in_ready;
  assign w_ordy[0] = if0.out_ready; assign w_ordy[1] = if1.out_ready;
  assign w_or[0] = if0.out_r;      assign w_or[1] = if1.out_r;
  assign w_cu[0] = if0.core_u;     assign w_cu[1] = if1.core_u;
  assign w_cv[0] = if0.core_v;     assign w_cv[1] = if1.core_v;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  task automatic set_in(input int inst, input logic v, input logic [15:0] a, input logic [15:0] b);
    if (inst == 0) begin
      if0.in_valid = v; if0.in_a = a; if0.in_b = b;
    end else begin
      if1.in_valid = v; if1.in_a = a; if1.in_b = b;
    end
  endtask

  function automatic int qsize(input int inst);
    return (inst == 0) ? q0.size() : q1.size();
  endfunction

  // Offer one operand pair; the expected product is pushed when acceptance is seen.
  task automatic send(input int inst, input logic [15:0] a, input logic [15:0] b,
                      input logic [31:0] res);
    exp_t e;
    bit   accepted = 1'b0;
    int   n = 0;
    set_in(inst, 1'b1, a, b);
    while (!accepted && n < 200) begin
      @(negedge clk);
      if (rst_n && w_ir[inst]) begin
        accepted = 1'b1;
        e.res = res;
        e.acc = cyc + 1;
        if (inst == 0) q0.push_back(e); else q1.push_back(e);
      end
      n++;
      @(posedge clk);
      #1;
    end
    set_in(inst, 1'b0, 16'd0, 16'd0);
    if (!accepted) fail_now($sformatf("accept_timeout%0d", inst));
  endtask

  task automatic drain(input int inst);
    int n = 0;
    while (qsize(inst) != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (qsize(inst) != 0) fail_now($sformatf("drain_timeout%0d", inst));
    @(posedge clk);
    #1;
  endtask

  task automatic mon_step(input int i);
    exp_t e;
    bit   have = 1'b0;
    if (i == 0) begin
      if (q0.size() > 0) begin e = q0[0]; have = 1'b1; end
    end else begin
      if (q1.size() > 0) begin e = q1[0]; have = 1'b1; end
    end
    if (after_take[i]) begin
      chk($sformatf("idle_after_take%0d", i), {62'd0, w_ir[i], w_ov[i]}, 64'd2);
      after_take[i] = 1'b0;
    end
    if (w_ir[i] || w_ov[i])
      chk($sformatf("core_zero%0d", i), {46'd0, w_cu[i], w_cv[i]}, 64'd0);
    if (w_ov[i]) begin
      if (!have) begin
        fail_now($sformatf("spurious_out_valid%0d", i));
      end else begin
        chk($sformatf("result%0d", i), {32'd0, w_or[i]}, {32'd0, e.res});
        chk($sformatf("busy_in_ready%0d", i), {63'd0, w_ir[i]}, 64'd0);
        if (!prev_valid[i])
          chk($sformatf("latency%0d", i), 64'(cyc - e.acc), 64'(lat[i]));
        if (w_ordy[i]) begin
          if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
          after_take[i] = 1'b1;
        end
      end
    end
    prev_valid[i] = w_ov[i];
  endtask

  // Monitor: compares every presented result against the scoreboard heads.
  always @(negedge clk) begin
    if (!rst_n || !mon_en) begin
      for (int i = 0; i < 2; i++) begin
        prev_valid[i] = 1'b0;
        after_take[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) mon_step(i);
    end
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [15:0] ra;
    logic [15:0] rb;
    lat[0] = 3;
    lat[1] = 9;
    set_in(0, 1'b0, 16'd0, 16'd0);
    set_in(1, 1'b0, 16'd0, 16'd0);
    if0.out_ready = 1'b1;
    if1.out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", {62'd0, if0.out_valid, if1.out_valid}, 64'd0);
    chk("rst_out_r0", {32'd0, if0.out_r}, 64'd0);
    chk("rst_out_r1", {32'd0, if1.out_r}, 64'd0);
    chk("rst_in_ready", {62'd0, if0.in_ready, if1.in_ready}, 64'd3);
    chk("rst_core", {28'd0, if0.core_u, if0.core_v, if1.core_u, if1.core_v}, 64'd0);
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // Both halves all-ones: carries in the PM pass
    send(0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
    drain(0);

    // Zero operand, then a single-bit upper-half product
    send(0, 16'h0000, 16'h1234, 32'h00000000);
    send(0, 16'h0100, 16'h0100, 32'h00010000);
    drain(0);

    // Back-pressure: result held for 5 cycles
    if0.out_ready = 1'b0;
    send(0, 16'd300, 16'd500, 32'd150000);
    n = 0;
    while (!if0.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!if0.out_valid) fail_now("hold_wait_timeout");
    repeat (5) @(negedge clk);
    chk("hold_out_r", {32'd0, if0.out_r}, 64'd150000);
    @(posedge clk);
    #1 if0.out_ready = 1'b1;
    drain(0);

    // Reset in the middle of the PM pass abandons the operation
    send(0, 16'h1234, 16'h5678, 32'h06260060);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {63'd0, if0.out_valid}, 64'd0);
    chk("midrst_in_ready", {63'd0, if0.in_ready}, 64'd1);
    chk("midrst_core", {46'd0, if0.core_u, if0.core_v}, 64'd0);
    q0.delete();
    q1.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    send(0, 16'd7, 16'd9, 32'd63);
    drain(0);

    // Random operands and random sink readiness through the latency-2 core
    fork
      begin
        for (int k = 0; k < 1000; k++) begin
          ra = 16'($urandom_range(0, 65535));
          rb = 16'($urandom_range(0, 65535));
          send(1, ra, rb, {16'd0, ra} * {16'd0, rb});
        end
        drain(1);
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 if1.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    if1.out_ready = 1'b1;
    drain(1);

`ifdef KARA_SEQ_CHECK_EN
    chk("err_flags", {62'd0, err0, err1}, 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
